// File: rtl/cache_axi_bridge_pkg.sv
// Shared encodings and helpers for the cache-to-AXI bridge.
package cache_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned STRB_W = 16;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned RESP_W = 2;

  // Cache request type encodings (shared by read and write ports)
  localparam logic [TYPE_W-1:0] TYPE_BYTE = 3'b000;
  localparam logic [TYPE_W-1:0] TYPE_HALF = 3'b001;
  localparam logic [TYPE_W-1:0] TYPE_WORD = 3'b010;
  localparam logic [TYPE_W-1:0] TYPE_LINE = 3'b100;

  // AXI response codes
  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  // Request type -> AXI size; unknown codes are treated as a word access
  function automatic logic [SIZE_W-1:0] type_to_size(input logic [TYPE_W-1:0] t);
    case (t)
      TYPE_BYTE: type_to_size = SIZE_W'(0);
      TYPE_HALF: type_to_size = SIZE_W'(1);
      TYPE_WORD: type_to_size = SIZE_W'(2);
      TYPE_LINE: type_to_size = SIZE_W'(4);
      default:   type_to_size = SIZE_W'(2);
    endcase
  endfunction

endpackage

// File: rtl/cache_axi_bridge.sv
// Single-outstanding, single-beat bridge from cache read/write requests to AXI.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  // cache read port
  input  logic              rd_req,
  input  logic [TYPE_W-1:0] rd_type,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rdy,
  output logic              ret_valid,
  output logic              ret_last,
  output logic [DATA_W-1:0] ret_data,
  // cache write port
  input  logic              wr_req,
  input  logic [TYPE_W-1:0] wr_type,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [STRB_W-1:0] wr_wstrb,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_rdy,
  // AR channel
  output logic [ADDR_W-1:0] araddr,
  output logic [SIZE_W-1:0] arsize,
  output logic              arvalid,
  input  logic              arready,
  // R channel
  input  logic [DATA_W-1:0] rdata,
  input  logic [RESP_W-1:0] rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AW channel
  output logic [ADDR_W-1:0] awaddr,
  output logic [SIZE_W-1:0] awsize,
  output logic              awvalid,
  input  logic              awready,
  // W channel
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  // B channel
  input  logic [RESP_W-1:0] bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              bus_err
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              bus_err_q, bus_err_d;

  // State, latched payload, handshake flags and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      type_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state, acceptance latching and channel handshake decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    type_d    = type_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bus_err_d = 1'b0;

    wr_rdy    = 1'b0;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = '0;

    case (state_q)
      S_IDLE: begin
        wr_rdy = 1'b1;
        rd_rdy = ~wr_req;
        if (wr_req) begin
          addr_d    = wr_addr;
          type_d    = wr_type;
          wstrb_d   = wr_wstrb;
          wdata_d   = wr_data;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR;
        end else if (rd_req) begin
          addr_d  = rd_addr;
          type_d  = rd_type;
          state_d = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          ret_valid = 1'b1;
          ret_last  = rlast;
          ret_data  = rdata;
          bus_err_d = (rresp != RESP_OKAY);
          if (rlast) state_d = S_IDLE;
        end
      end
      S_WR: begin
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q | (wvalid & wready);
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          bus_err_d = (bresp != RESP_OKAY);
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Payloads come straight from the latch so they stay stable until handshake
  assign araddr  = (type_q == TYPE_LINE) ? {addr_q[ADDR_W-1:4], 4'b0000} : addr_q;
  assign arsize  = type_to_size(type_q);
  assign awaddr  = addr_q;
  assign awsize  = type_to_size(type_q);
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed, table-driven bench for cache_axi_bridge.
module tb_cache_axi_bridge;
  import cache_axi_bridge_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req, wr_req;
  logic [2:0]   rd_type, wr_type;
  logic [31:0]  rd_addr, wr_addr;
  logic [15:0]  wr_wstrb;
  logic [127:0] wr_data;
  logic         rd_rdy, wr_rdy, ret_valid, ret_last;
  logic [127:0] ret_data;
  logic [31:0]  araddr, awaddr;
  logic [2:0]   arsize, awsize;
  logic         arvalid, arready, rready, rlast, rvalid;
  logic [127:0] rdata, wdata;
  logic [1:0]   rresp, bresp;
  logic         awvalid, awready, wvalid, wready, bvalid, bready, bus_err;
  logic [15:0]  wstrb;

  always #5 clk = ~clk;

  cache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bus_err(bus_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0]  addr;
    logic [2:0]   typ;
    logic [127:0] data;
    logic [1:0]   resp;
    int           ar_delay;
    logic [31:0]  exp_araddr;
    logic [2:0]   exp_size;
    logic         exp_err;
  } rd_vec_t;

  typedef struct {
    logic [31:0]  addr;
    logic [2:0]   typ;
    logic [15:0]  strb;
    logic [127:0] data;
    int           aw_delay;
    int           w_delay;
    logic [1:0]   resp;
    logic [2:0]   exp_size;
    logic         exp_err;
  } wr_vec_t;

  rd_vec_t rv[8];
  wr_vec_t wv[5];

  task automatic do_read(input rd_vec_t v);
    rd_req = 1'b1; rd_addr = v.addr; rd_type = v.typ;
    #1 check("rd_rdy_idle", rd_rdy, 1'b1);
    step();
    rd_req = 1'b0; rd_addr = 32'hFFFF_FFF0; rd_type = 3'b001;
    #1;
    check("arvalid", arvalid, 1'b1);
    check("araddr", araddr, v.exp_araddr);
    check("arsize", arsize, v.exp_size);
    check("rd_rdy_busy", rd_rdy, 1'b0);
    for (int i = 0; i < v.ar_delay; i++) begin
      step();
      check("arvalid_hold", arvalid, 1'b1);
      check("araddr_hold", araddr, v.exp_araddr);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    #1;
    check("arvalid_drop", arvalid, 1'b0);
    check("rready", rready, 1'b1);
    check("ret_valid_wait", ret_valid, 1'b0);
    rvalid = 1'b1; rdata = v.data; rlast = 1'b1; rresp = v.resp;
    #1;
    check("ret_valid", ret_valid, 1'b1);
    check("ret_data", ret_data, v.data);
    check("ret_last", ret_last, 1'b1);
    step();
    rvalid = 1'b0; rlast = 1'b0; rresp = RESP_OKAY;
    #1;
    check("rd_bus_err", bus_err, v.exp_err);
    check("ret_valid_off", ret_valid, 1'b0);
    check("rready_off", rready, 1'b0);
    check("rd_rdy_back", rd_rdy, 1'b1);
    step();
    check("rd_bus_err_pulse", bus_err, 1'b0);
  endtask

  task automatic do_write(input wr_vec_t v);
    int last;
    last = (v.aw_delay > v.w_delay) ? v.aw_delay : v.w_delay;
    wr_req = 1'b1; wr_addr = v.addr; wr_type = v.typ; wr_wstrb = v.strb; wr_data = v.data;
    #1 check("wr_rdy_idle", wr_rdy, 1'b1);
    step();
    wr_req = 1'b0; wr_addr = 32'h0; wr_wstrb = 16'h0; wr_data = '0; wr_type = 3'b000;
    #1;
    check("awaddr", awaddr, v.addr);
    check("awsize", awsize, v.exp_size);
    check("wdata", wdata, v.data);
    check("wstrb", wstrb, v.strb);
    check("wr_rdy_busy", wr_rdy, 1'b0);
    for (int c = 0; c <= last; c++) begin
      check("awvalid", awvalid, (c <= v.aw_delay));
      check("wvalid", wvalid, (c <= v.w_delay));
      awready = (c == v.aw_delay);
      wready  = (c == v.w_delay);
      step();
      awready = 1'b0; wready = 1'b0;
      #1;
    end
    check("bready", bready, 1'b1);
    check("awvalid_b", awvalid, 1'b0);
    check("wvalid_b", wvalid, 1'b0);
    step();
    check("wr_rdy_b", wr_rdy, 1'b0);
    bvalid = 1'b1; bresp = v.resp;
    step();
    bvalid = 1'b0; bresp = RESP_OKAY;
    #1;
    check("wr_rdy_back", wr_rdy, 1'b1);
    check("bready_off", bready, 1'b0);
    check("wr_bus_err", bus_err, v.exp_err);
    step();
    check("wr_bus_err_pulse", bus_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rv[0] = '{32'h1C00_0004, TYPE_WORD, 128'h1111_2222_3333_4444_5555_6666_7777_8888, RESP_OKAY,   2, 32'h1C00_0004, 3'd2, 1'b0};
    rv[1] = '{32'h1C00_0008, TYPE_LINE, 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F, RESP_OKAY,   0, 32'h1C00_0000, 3'd4, 1'b0};
    rv[2] = '{32'h1C00_000B, TYPE_BYTE, 128'h0000_0000_0000_0000_0000_0000_00AB_0000, RESP_OKAY,   1, 32'h1C00_000B, 3'd0, 1'b0};
    rv[3] = '{32'h1C00_000E, TYPE_HALF, 128'hBEEF_0000_0000_0000_0000_0000_0000_0000, RESP_OKAY,   0, 32'h1C00_000E, 3'd1, 1'b0};
    rv[4] = '{32'h1C00_0010, 3'b011,    128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, RESP_OKAY,   0, 32'h1C00_0010, 3'd2, 1'b0};
    rv[5] = '{32'h1C00_001F, 3'b111,    128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210, RESP_OKAY,   0, 32'h1C00_001F, 3'd2, 1'b0};
    rv[6] = '{32'h1C00_0030, TYPE_WORD, 128'hCAFE_F00D_0000_0000_0000_0000_DEAD_BEEF, RESP_SLVERR, 0, 32'h1C00_0030, 3'd2, 1'b1};
    rv[7] = '{32'h1C00_003C, TYPE_LINE, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, RESP_DECERR, 1, 32'h1C00_0030, 3'd4, 1'b1};

    wv[0] = '{32'h1C00_0008, TYPE_WORD, 16'h0F00, {32'h0, 32'hDEAD_BEEF, 64'h0},    0, 3, RESP_OKAY,   3'd2, 1'b0};
    wv[1] = '{32'h1C00_0001, TYPE_BYTE, 16'h0002, {112'h0, 8'h5A, 8'h00},           0, 0, RESP_OKAY,   3'd0, 1'b0};
    wv[2] = '{32'h1C00_0006, TYPE_HALF, 16'h00C0, {64'h0, 16'h1234, 48'h0},         2, 0, RESP_OKAY,   3'd1, 1'b0};
    wv[3] = '{32'h1C00_0010, TYPE_LINE, 16'hFFFF, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 1, 1, RESP_OKAY, 3'd4, 1'b0};
    wv[4] = '{32'h1C00_0020, 3'b110,    16'h000F, {96'h0, 32'h7777_8888},           0, 1, RESP_SLVERR, 3'd2, 1'b1};

    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; rd_type = '0; wr_type = '0;
    rd_addr = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
    repeat (3) step();
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_ret_valid", ret_valid, 1'b0);
    check("rst_ret_last", ret_last, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_wr_rdy", wr_rdy, 1'b1);
    check("rst_rd_rdy", rd_rdy, 1'b1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) do_read(rv[i]);
    for (int i = 0; i < 5; i++) do_write(wv[i]);

    // Simultaneous read and write: write wins, read follows after B
    rd_req = 1'b1; rd_addr = 32'h1C00_0044; rd_type = TYPE_WORD;
    wr_req = 1'b1; wr_addr = 32'h1C00_0080; wr_type = TYPE_WORD;
    wr_wstrb = 16'h000F; wr_data = 128'h9999;
    #1;
    check("both_rd_rdy", rd_rdy, 1'b0);
    check("both_wr_rdy", wr_rdy, 1'b1);
    step();
    wr_req = 1'b0;
    #1;
    check("both_awvalid", awvalid, 1'b1);
    check("both_arvalid", arvalid, 1'b0);
    check("both_awaddr", awaddr, 32'h1C00_0080);
    check("both_rd_rdy_wr", rd_rdy, 1'b0);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    #1;
    check("both_bready", bready, 1'b1);
    check("both_rd_rdy_b", rd_rdy, 1'b0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    #1;
    check("both_rd_rdy_after_b", rd_rdy, 1'b1);
    step();
    rd_req = 1'b0;
    #1;
    check("both_arvalid_rd", arvalid, 1'b1);
    check("both_araddr", araddr, 32'h1C00_0044);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 128'h4242;
    #1;
    check("both_ret_data", ret_data, 128'h4242);
    step();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("both_idle", rd_rdy, 1'b1);

    // Reset while waiting in R abandons the read
    rd_req = 1'b1; rd_addr = 32'h1C00_0100; rd_type = TYPE_LINE;
    step();
    rd_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    #1;
    check("pre_rst_rready", rready, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_rready", rready, 1'b0);
    check("mid_rst_rd_rdy", rd_rdy, 1'b1);
    check("mid_rst_wr_rdy", wr_rdy, 1'b1);
    check("mid_rst_arvalid", arvalid, 1'b0);
    check("mid_rst_araddr", araddr, 32'h0);
    step();
    check("post_rst_rready", rready, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 Parameters: none; single-beat AXI only (len 0, INCR, fixed ID, wlast=1 tied off at top level).
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rd_req in 1, rd_type in 3, rd_addr in 32: cache read request; type 000 byte, 001 half, 010 word, 100 line.
REQ-005 rd_rdy out 1: read accepted in any cycle with rd_req & rd_rdy.
REQ-006 ret_valid out 1, ret_last out 1, ret_data out 128: read return beat.
REQ-007 wr_req in 1, wr_type in 3, wr_addr in 32, wr_wstrb in 16, wr_data in 128: cache write request, data already lane-placed.
REQ-008 wr_rdy out 1: write accepted in any cycle with wr_req & wr_rdy.
REQ-009 AR channel: araddr out 32, arsize out 3, arvalid out 1, arready in 1.
REQ-010 R channel: rdata in 128, rresp in 2, rlast in 1, rvalid in 1, rready out 1.
REQ-011 AW channel: awaddr out 32, awsize out 3, awvalid out 1, awready in 1.
REQ-012 W channel: wdata out 128, wstrb out 16, wvalid out 1, wready in 1.
REQ-013 B channel: bresp in 2, bvalid in 1, bready out 1.
REQ-014 bus_err out 1: one-cycle pulse on non-OKAY rresp or bresp.

Function
REQ-015 FSM states: IDLE, AR, R, WR (AW+W), B; at most one transaction outstanding.
REQ-016 Ready logic: wr_rdy = IDLE; rd_rdy = IDLE & ~wr_req.
- Neither ready depends combinationally on its own req.
- Write wins simultaneous requests.
REQ-017 Acceptance in IDLE:
- wr_req: latch addr/type/wstrb/data, go WR.
- else rd_req: latch addr/type, go AR.
REQ-018 AR state: arvalid=1; araddr = latched addr with [3:0] zeroed for type 100, else unmodified; go R on arready.
REQ-019 Size map (rd and wr): 000->0, 001->1, 010->2, 100->4; any other code maps as 010.
REQ-020 R state: rready=1.
- On rvalid, same cycle: ret_valid=1, ret_data=rdata, ret_last=rlast (combinational pass-through).
- rvalid & rlast -> IDLE.
- ret_valid=0 in all other states.
REQ-021 WR state: awvalid and wvalid both rise the cycle after acceptance.
- Each drops independently after its own handshake, tracked by aw_done/w_done flags.
- Go B when both done; a same-cycle double handshake goes B directly.
REQ-022 Write payload: awaddr, wdata, wstrb = latched values unmodified; awsize from wr_type.
REQ-023 B state: bready=1; bvalid -> IDLE; wr_rdy stays low until then.
REQ-024 Valid/payload stability:
- Every AXI valid and its payload hold stable until handshake.
- Latched payload changes only on acceptance in IDLE.
REQ-025 bus_err: registered, high the cycle after (rvalid & rresp!=0) or (bvalid & bresp!=0); read data is still returned.
REQ-026 Latency:
- Acceptance -> arvalid or awvalid/wvalid: 1 cycle.
- Final R/B handshake -> rd_rdy/wr_rdy high: next cycle.

Reset
REQ-027 On rst: state IDLE; arvalid, awvalid, wvalid, rready, bready, ret_valid, ret_last, bus_err = 0; done flags and latched payload cleared.
REQ-028 Reset mid-transaction abandons it with no AXI cleanup; wr_rdy=1 (rd_rdy=~wr_req) the first cycle after rst falls.

Structure
REQ-029 Shared package holds: rd/wr type encodings (BYTE/HALF/WORD/LINE), AXI resp constants, the type->size function. FSM enum stays local.
REQ-030 No sub-module.

Verification
REQ-031 Word read: rd_addr 0x1C000004, type 010, arready 2 cycles late -> araddr 0x1C000004, arsize 2; rd_rdy low until R; ret_valid one cycle with rdata.
REQ-032 Line read: rd_addr 0x1C000008, type 100 -> araddr 0x1C000000, arsize 4, ret_last=1 with ret_valid.
REQ-033 Word write: addr 0x1C000008, wstrb 16'h0F00, data in [95:64]; awready 3 cycles before wready -> awvalid drops after AW, wvalid held, then B; wr_rdy=1 cycle after bvalid.
REQ-034 rd_req and wr_req together in IDLE -> write accepted, rd_rdy=0; read accepted the cycle after bvalid.
REQ-035 rresp=2'b10 -> ret_valid with data; bus_err high exactly one cycle, the next cycle.
REQ-036 rst in R state -> next cycle IDLE, rready=0, rd_rdy=1.
